// File: rtl/icache_if.sv
// Fetcher and memory-controller signal bundle for the icache.
// slave is the cache side; master is the fetcher/memory side that drives it.
`timescale 1ns/1ps
interface icache_if;
   logic          rdy;
   logic [31:0]   pc_from_fch;
   logic          enable_sign_from_fch;
   logic          hit_sign_to_fch;
   logic [31:0]   inst_to_fch;
   logic          clear_sign;
   logic [31:0]   pc_to_mem;
   logic          enable_sign_to_mem;
   logic          finish_sign_from_mem;
   logic [127:0]  inst_block_from_mem;

   modport slave (
      input  rdy, pc_from_fch, enable_sign_from_fch, clear_sign,
             finish_sign_from_mem, inst_block_from_mem,
      output hit_sign_to_fch, inst_to_fch, pc_to_mem, enable_sign_to_mem
   );

   modport master (
      output rdy, pc_from_fch, enable_sign_from_fch, clear_sign,
             finish_sign_from_mem, inst_block_from_mem,
      input  hit_sign_to_fch, inst_to_fch, pc_to_mem, enable_sign_to_mem
   );
endinterface

// File: rtl/icache.sv
// Direct-mapped instruction cache, 16-byte lines, one outstanding line fill.
// Define ICACHE_FORWARD_EN to forward the fill word to the fetcher in the finish cycle.
`timescale 1ns/1ps
module icache #(
   parameter int INDEX_BITS = 4
) (
   input  logic     clk,
   input  logic     rst,
   icache_if.slave  bus
);
   localparam int LINES    = 1 << INDEX_BITS;
   localparam int TAG_BITS = 28 - INDEX_BITS;

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_MISS = 1'b1
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [LINES-1:0]     r_valid;
   logic [TAG_BITS-1:0]  r_tag  [LINES];
   logic [127:0]         r_data [LINES];
   logic [31:0]          r_pending_addr;
   logic                 r_pending_drop;
   logic                 r_mem_en;

   logic [INDEX_BITS-1:0] w_index;
   logic [INDEX_BITS-1:0] w_fill_index;
   logic [TAG_BITS-1:0]   w_tag;
   logic [31:0]           w_line_addr;
   logic [127:0]          w_line;
   logic                  w_lookup_hit;
   logic                  w_hit;
   logic                  w_miss;
   logic                  w_fill;
   logic [31:0]           w_inst;
   logic                  w_unused_ok;

   function automatic logic [31:0] select_word(input logic [127:0] blk, input logic [1:0] sel);
      logic [31:0] word;
      case (sel)
         2'd0:    word = blk[31:0];
         2'd1:    word = blk[63:32];
         2'd2:    word = blk[95:64];
         2'd3:    word = blk[127:96];
         default: word = 32'h0000_0000;
      endcase
      return word;
   endfunction

   assign w_index      = bus.pc_from_fch[3+INDEX_BITS:4];
   assign w_tag        = bus.pc_from_fch[31:4+INDEX_BITS];
   assign w_line_addr  = {bus.pc_from_fch[31:4], 4'b0000};
   assign w_fill_index = r_pending_addr[3+INDEX_BITS:4];
   assign w_line       = r_data[w_index];
   assign w_lookup_hit = r_valid[w_index] && (r_tag[w_index] == w_tag);
   assign w_unused_ok  = ^{bus.pc_from_fch[1:0], r_pending_drop};

   assign bus.hit_sign_to_fch    = w_hit;
   assign bus.inst_to_fch        = w_inst;
   assign bus.enable_sign_to_mem = r_mem_en;
   assign bus.pc_to_mem          = r_pending_addr;

   // State register; rdy low freezes it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else if (bus.rdy) begin
         r_state <= w_state_nxt;
      end else begin
         r_state <= r_state;
      end
   end

   // Next state, lookup result and fill strobe.
   always_comb begin
      w_state_nxt = r_state;
      w_hit       = 1'b0;
      w_inst      = 32'h0000_0000;
      w_miss      = 1'b0;
      w_fill      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.rdy && bus.enable_sign_from_fch) begin
               if (w_lookup_hit) begin
                  w_hit  = 1'b1;
                  w_inst = select_word(w_line, bus.pc_from_fch[3:2]);
               end else begin
                  w_miss      = 1'b1;
                  w_state_nxt = S_MISS;
               end
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_MISS: begin
            if (bus.rdy && bus.finish_sign_from_mem) begin
               w_fill      = 1'b1;
               w_state_nxt = S_IDLE;
`ifdef ICACHE_FORWARD_EN
               // A flush in the finish cycle itself also suppresses forwarding.
               if (bus.enable_sign_from_fch && !r_pending_drop && !bus.clear_sign &&
                   (w_line_addr == r_pending_addr)) begin
                  w_hit  = 1'b1;
                  w_inst = select_word(bus.inst_block_from_mem, bus.pc_from_fch[3:2]);
               end else begin
                  w_hit  = 1'b0;
               end
`endif
            end else begin
               w_state_nxt = S_MISS;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Miss bookkeeping, request pulse and valid bits.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid        <= '0;
         r_pending_addr <= 32'h0000_0000;
         r_pending_drop <= 1'b0;
         r_mem_en       <= 1'b0;
      end else if (bus.rdy) begin
         r_mem_en <= w_miss;
         if (w_miss) begin
            r_pending_addr <= w_line_addr;
            r_pending_drop <= 1'b0;
         end else if ((r_state == S_MISS) && bus.clear_sign) begin
            r_pending_drop <= 1'b1;
         end else begin
            r_pending_drop <= r_pending_drop;
         end
         if (w_fill) begin
            r_valid[w_fill_index] <= 1'b1;
         end
      end else begin
         r_mem_en <= r_mem_en;
      end
   end

   // Tag and data arrays need no reset; valid bits gate every read.
   always_ff @(posedge clk) begin
      if (w_fill) begin
         r_tag[w_fill_index]  <= r_pending_addr[31:4+INDEX_BITS];
         r_data[w_fill_index] <= bus.inst_block_from_mem;
      end
   end
endmodule

// File: doc/icache.md
# icache

Direct-mapped instruction cache between the instruction fetcher and the memory controller. It serves 32-bit instruction words to the fetcher from 16-byte lines. On a miss it issues one line-fill request to the memory controller's fetch port and installs the returned 128-bit block. It stays quiet while a fill is outstanding, because the memory controller buffers every asserted request.

## Interface
Parameters:
- INDEX_BITS, 4, line-index width; the cache holds 2^INDEX_BITS lines of 16 bytes each.

Ports (clock and reset first). Reset is asynchronous and active-high.
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- rdy  in  1  global ready; low freezes all state.
- pc_from_fch  in  32  fetch address; bits [1:0] ignored.
- enable_sign_from_fch  in  1  fetcher requests the word at pc_from_fch this cycle.
- hit_sign_to_fch  out  1  inst_to_fch is valid for pc_from_fch this cycle.
- inst_to_fch  out  32  instruction word.
- clear_sign  in  1  pipeline flush: drop any pending forward; valid bits are kept.
- pc_to_mem  out  32  line address, {pc[31:4], 4'b0}.
- enable_sign_to_mem  out  1  line-fill request, one-cycle pulse.
- finish_sign_from_mem  in  1  fill complete, one-cycle pulse.
- inst_block_from_mem  in  128  line data; byte k is at [8k+7:8k].

## Operation
- Address split:
  - offset = pc[3:0]; word select = pc[3:2].
  - index = pc[3+INDEX_BITS:4]; tag = pc[31:4+INDEX_BITS].
- Storage per line: valid bit, tag, 128-bit data. Word w of a line is data[32w+31:32w].
- Hit logic (combinational):
  - hit = state==IDLE && rdy && enable_sign_from_fch && valid[index] && tag match.
  - inst_to_fch = selected word on a hit, else 0.
- States:
  - IDLE: on enable with no hit, latch pending_addr = {pc[31:4],4'b0} and clear pending_drop. Pulse enable_sign_to_mem with pc_to_mem = pending_addr, then go to MISS.
  - MISS: enable_sign_to_mem is low; pc_to_mem holds pending_addr. On finish_sign_from_mem, write data, tag and valid for pending_addr's index, then return to IDLE.
- clear_sign:
  - In MISS: set pending_drop. The fill still completes and is installed (the memory controller cannot abort), but it is never forwarded.
  - In IDLE: no effect.
- A fetcher request in MISS gets hit_sign_to_fch=0; the fetcher keeps retrying.
- While rdy=0: no edge updates state; hit_sign_to_fch=0; a finish pulse is not expected.
- Reset mid-MISS: state returns to IDLE and all valid bits clear. A later stale finish pulse in IDLE is ignored.
- Reset values: hit_sign_to_fch=0, inst_to_fch=0, enable_sign_to_mem=0, pc_to_mem=0, state=IDLE, all valid=0.

## Timing
- Hit: same-cycle, zero latency.
- Miss detected in cycle T:
  - enable_sign_to_mem=1 during T+1 only.
  - pc_to_mem stays valid from T+1 until the finish cycle F.
- Line is visible to lookups from cycle F+1.
- Miss latency from the memory controller is about 18 cycles (16 byte reads plus overhead); the cache places no bound on it.
- At most one fill is outstanding; no second pulse is sent before finish.
- A finish pulse arriving in IDLE is ignored.

## Configuration
- ICACHE_FORWARD_EN defined: in cycle F, if enable_sign_from_fch is high, pending_drop=0, and {pc[31:4],4'b0}==pending_addr, then hit_sign_to_fch=1 and inst_to_fch comes directly from inst_block_from_mem word pc[3:2]. The line is also written.
- Undefined: no forwarding; first hit at F+1 through normal lookup.

## Test plan
- Reset, then enable with pc=0x0000_1004 -> T+1 has enable_sign_to_mem=1 and pc_to_mem=0x0000_1000 for one cycle. Finish with block word1=0x0010_0093 -> hit at F+1 (F with FORWARD_EN), inst_to_fch=0x0010_0093.
- After that fill, pc=0x0000_100C -> same-cycle hit with word3; no memory request issued.
- Conflict test with INDEX_BITS=4: fill 0x0000_1000, then request 0x0000_1100 (same index, different tag) -> miss and refill. Re-request 0x0000_1000 -> miss again.
- Assert clear_sign during MISS, then finish -> no forward in F; the line is installed and hits at F+1 when re-requested.
- Hold enable for 20 cycles during MISS -> hit_sign_to_fch stays 0 and enable_sign_to_mem pulses exactly once. With rdy=0 for 3 cycles -> state and outputs freeze.
- Assert rst in MISS, then a stray finish -> state IDLE, all lines miss, and the stray finish installs nothing.
